clk_div_monitor: RTL and testbench
==================================

# clk_div_monitor

Measures a divided clock that is generated in, and sampled by, the `clk` domain, such as a divide-by-3 output. For each period it reports the period length and high time in `clk` cycles, and checks both against expected values. It asserts `locked` after a run of consecutive good periods, and flags bad periods and a stuck input. It sits at the receiving end of the team's clock dividers, both as an on-chip health monitor and as a reusable checker for divider verification.

## Interface
- `CNT_W`, default 8: width of the cycle counters and measurement outputs. Saturation value is 2^CNT_W-1.
- `EXP_PERIOD`, default 3: expected period in `clk` cycles.
- `EXP_HIGH`, default 2: expected high time in `clk` cycles.
- `LOCK_COUNT`, default 4: number of consecutive good measurements required for `locked`. Must be 1 to 15.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `en`, input, 1: monitor enable. Level-sensitive, synchronous.
- `div_in`, input, 1: divided clock under test. Synchronous to `clk`; no synchronizer.
- `period`, output, CNT_W: last measured period, in cycles from rise to rise.
- `high_time`, output, CNT_W: last measured high time, in cycles from rise to fall.
- `meas_valid`, output, 1: one-cycle pulse; `period`/`high_time` updated this cycle.
- `err`, output, 1: one-cycle pulse on a bad measurement or on timeout.
- `locked`, output, 1: level; LOCK_COUNT consecutive good measurements seen.
- `timeout`, output, 1: level; no rising edge for 2^CNT_W-1 cycles.

## Operation
- Edge detection:
  - `div_q` is `div_in` registered; reset value 0.
  - rise = `div_in` & ~`div_q`.
  - fall = ~`div_in` & `div_q`.
  - `div_q` updates regardless of `en`, so no false edge occurs on enable.
- Counter `cnt` (CNT_W bits, reset 0):
  - On rise: `cnt` <= 1.
  - Otherwise: `cnt` <= `cnt`+1, saturating at MAX = 2^CNT_W-1.
- On fall: `hcap` <= `cnt` (internal, reset 0).
- FSM, two states, reset to ARM:
  - ARM: waiting for a reference edge. A rise moves to MEAS; no measurement is made.
  - MEAS: a rise captures `period` <= `cnt`, `high_time` <= `hcap`, and pulses `meas_valid`. The state stays MEAS.
- A measurement is good iff `cnt`==EXP_PERIOD and `hcap`==EXP_HIGH, both evaluated on the rise cycle.
  - Good measurement: `good_cnt` <= min(`good_cnt`+1, LOCK_COUNT).
  - Bad measurement: pulse `err`, `good_cnt` <= 0, `locked` <= 0.
- `locked` = (`good_cnt`==LOCK_COUNT), registered so it updates with the same edge as `good_cnt`.
- Timeout:
  - On the edge where `cnt` goes from MAX-1 to MAX with no rise: pulse `err` once, set `timeout`=1, `good_cnt` <= 0, `locked` <= 0, state <= ARM.
  - `timeout` stays high until the next rise, which clears it.
  - `cnt` runs in both states, so a stuck input after reset also times out.
- `en`=0:
  - Each cycle forces state ARM, `cnt` 0, `good_cnt` 0, `locked` 0, `timeout` 0.
  - No `meas_valid` or `err` pulses are produced.
  - `period`, `high_time` and `hcap` hold their values.

## Timing
- Reset values:
  - `period`=0, `high_time`=0.
  - `meas_valid`=0, `err`=0, `locked`=0, `timeout`=0.
  - `cnt`=0, `hcap`=0, `good_cnt`=0, `div_q`=0, state ARM.
- All outputs are registered.
  - Measurement latency: outputs change on the clock edge that ends the rise cycle, and `meas_valid` is high for exactly the following cycle.
- First measurement comes on the second rise after reset, enable, or timeout.
- Simultaneous events:
  - Rise on the cycle `cnt` would reach MAX: the rise wins and no timeout occurs.
  - Rise while `cnt`==MAX: treated as an ARM rise; no measurement.
- A good measurement and `locked` reaching 1 take effect on the same edge, so `locked` rises together with the LOCK_COUNT-th `meas_valid`.
- A bad measurement drops `locked` on the same edge that pulses `err` and `meas_valid`.
- Reset mid-period: all state clears immediately; there is no partial measurement afterwards.

## Test plan
- Reset, then `en`=1 with `div_in` repeating 1,1,0 (rise at t0): `meas_valid` at t3, t6, t9, t12 (each visible the cycle after its rise edge), each with `period`=3 and `high_time`=2, and `err` never asserted. `locked` rises with the 4th `meas_valid`.
- While locked, insert one period of 1,0,0: that measurement gives `period`=3 and `high_time`=1, pulses `err` for 1 cycle, and clears `locked`. Four further good periods re-lock.
- Hold `div_in`=0 after lock: `err` pulses once and `timeout`=1 when `cnt` hits 255, `locked`=0. Resume 1,1,0: `timeout` clears on the first rise, and the first `meas_valid` comes on the second rise.
- Pattern 1,1,1,0 (period 4, high 3): every measurement gives `period`=4, `high_time`=3 and an `err` pulse; `locked` stays 0.
- Deassert `en` mid-stream for 5 cycles, then reassert: no pulses while `en`=0, `locked`=0, and the first new `meas_valid` comes on the second rise after re-enable.
- Assert `rst` asynchronously mid-period while locked: every output is 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor bus: enable, divided clock
// under test and measurement results.
interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             div_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             err;
  logic             locked;
  logic             timeout;

  modport master (
    output en, div_in,
    input  period, high_time,
    input  meas_valid, err,
    input  locked, timeout
  );

  modport slave (
    input  en, div_in,
    output period, high_time,
    output meas_valid, err,
    output locked, timeout
  );
endinterface

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: period/high-time
// measurement, lock tracking, stuck detect.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 3,
  parameter int EXP_HIGH   = 2,
  parameter int LOCK_COUNT = 4
) (
  input  logic            clk,
  input  logic            rst,
  clk_div_monitor_if.slave bus
);

  typedef enum logic {
    ARM,
    MEAS
  } state_t;

  localparam logic [CNT_W-1:0] MAX   = '1;
  localparam logic [CNT_W-1:0] MAXM1 =
    MAX - 1'b1;
  localparam logic [CNT_W-1:0] EXP_P =
    CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H =
    CNT_W'(EXP_HIGH);
  localparam logic [3:0] LOCK_N =
    4'(LOCK_COUNT);

  state_t           state_q;
  state_t           state_d;
  logic             div_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hcap;
  logic [3:0]       good_cnt;
  logic [3:0]       good_d;
  logic             do_meas;
  logic             good_m;
  logic             tmo_hit;

  assign rise   = bus.div_in & ~div_q;
  assign fall   = ~bus.div_in & div_q;
  assign good_m = (cnt == EXP_P) &&
                  (hcap == EXP_H);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARM;
    else     state_q <= state_d;
  end

  // next state, measure and timeout strobes
  always_comb begin
    state_d = state_q;
    do_meas = 1'b0;
    tmo_hit = 1'b0;
    if (!bus.en) begin
      state_d = ARM;
    end else if (rise) begin
      if (state_q == MEAS && cnt != MAX)
        do_meas = 1'b1;
      state_d = MEAS;
    end else if (cnt == MAXM1) begin
      tmo_hit = 1'b1;
      state_d = ARM;
    end
  end

  // next good-measurement run length
  always_comb begin
    good_d = good_cnt;
    if (!bus.en || tmo_hit) begin
      good_d = 4'd0;
    end else if (do_meas) begin
      if (!good_m)
        good_d = 4'd0;
      else if (good_cnt != LOCK_N)
        good_d = good_cnt + 4'd1;
    end
  end

  // edge-detect register runs even when disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= 1'b0;
    else     div_q <= bus.div_in;
  end

  // cycle counter and high-time capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      hcap <= '0;
    end else if (!bus.en) begin
      cnt  <= '0;
    end else begin
      if (rise)
        cnt <= CNT_W'(1);
      else if (cnt != MAX)
        cnt <= cnt + 1'b1;
      if (fall)
        hcap <= cnt;
    end
  end

  // measurement outputs and status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.period     <= '0;
      bus.high_time  <= '0;
      bus.meas_valid <= 1'b0;
      bus.err        <= 1'b0;
      bus.locked     <= 1'b0;
      bus.timeout    <= 1'b0;
      good_cnt       <= 4'd0;
    end else begin
      bus.meas_valid <= do_meas;
      bus.err        <= (do_meas & ~good_m) |
                        tmo_hit;
      good_cnt       <= good_d;
      bus.locked     <= (good_d == LOCK_N);
      if (do_meas) begin
        bus.period    <= cnt;
        bus.high_time <= hcap;
      end
      if (!bus.en)
        bus.timeout <= 1'b0;
      else if (rise)
        bus.timeout <= 1'b0;
      else if (tmo_hit)
        bus.timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor with a
// cycle model and measurement scoreboard.
module tb_clk_div_monitor;

  logic clk;
  logic rst;

  clk_div_monitor_if #(.CNT_W(8)) bus ();

  clk_div_monitor #(
    .CNT_W      (8),
    .EXP_PERIOD (3),
    .EXP_HIGH   (2),
    .LOCK_COUNT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    bit e;
    bit l;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;

  int m_len;
  int m_hi;
  int m_g;
  bit m_inhigh;
  bit m_ready;
  bit m_tmo;
  bit m_pd;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] want
  );
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d",
             tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_len    = 0;
    m_hi     = 0;
    m_g      = 0;
    m_inhigh = 1'b0;
    m_ready  = 1'b0;
    m_tmo    = 1'b0;
    m_pd     = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"}, 32'(bus.period), 0);
    check({tag, "_high"}, 32'(bus.high_time), 0);
    check({tag, "_mv"}, 32'(bus.meas_valid), 0);
    check({tag, "_err"}, 32'(bus.err), 0);
    check({tag, "_lock"}, 32'(bus.locked), 0);
    check({tag, "_tmo"}, 32'(bus.timeout), 0);
  endtask

  task automatic step(input bit d);
    bit   rise;
    bit   e_err;
    bit   e_mv;
    bit   good;
    exp_t x;
    rise  = d & ~m_pd;
    e_err = 1'b0;
    e_mv  = 1'b0;
    bus.div_in = d;
    if (!bus.en) begin
      m_len   = 0;
      m_ready = 1'b0;
      m_g     = 0;
      m_tmo   = 1'b0;
    end else if (rise) begin
      if (m_ready && m_len != 255) begin
        good = (m_len == 3) && (m_hi == 2);
        if (!good)      m_g = 0;
        else if (m_g < 4) m_g++;
        x.p = m_len;
        x.h = m_hi;
        x.e = !good;
        x.l = (m_g == 4);
        q.push_back(x);
        e_mv  = 1'b1;
        e_err = !good;
      end
      m_ready  = 1'b1;
      m_tmo    = 1'b0;
      m_len    = 1;
      m_hi     = 1;
      m_inhigh = 1'b1;
    end else begin
      if (m_len == 254) begin
        e_err   = 1'b1;
        m_tmo   = 1'b1;
        m_ready = 1'b0;
        m_g     = 0;
      end
      if (m_len != 255) m_len++;
      if (m_inhigh && d) m_hi++;
      else               m_inhigh = 1'b0;
    end
    m_pd = d;
    @(posedge clk);
    #1;
    check("err", 32'(bus.err), 32'(e_err));
    check("mv", 32'(bus.meas_valid), 32'(e_mv));
    check("locked", 32'(bus.locked),
          32'(m_g == 4));
    check("timeout", 32'(bus.timeout),
          32'(m_tmo));
  endtask

  task automatic per(input int h, input int l);
    repeat (h) step(1'b1);
    repeat (l) step(1'b0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst && bus.meas_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("sb_empty", 1, 0);
      end else begin
        x = q.pop_front();
        check("sb_period", 32'(bus.period), x.p);
        check("sb_high", 32'(bus.high_time), x.h);
        check("sb_err", 32'(bus.err), 32'(x.e));
        check("sb_lock", 32'(bus.locked),
              32'(x.l));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst        = 1'b1;
    bus.en     = 1'b0;
    bus.div_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    bus.en = 1'b1;
    repeat (5) per(2, 1);
    check("lock_after4", 32'(bus.locked), 1);

    per(1, 2);
    repeat (5) per(2, 1);
    check("relock", 32'(bus.locked), 1);

    repeat (260) step(1'b0);
    check("tmo_set", 32'(bus.timeout), 1);
    check("tmo_unlock", 32'(bus.locked), 0);
    repeat (6) per(2, 1);

    repeat (4) per(3, 1);
    repeat (3) per(2, 1);

    step(1'b1);
    bus.en = 1'b0;
    step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    bus.en = 1'b1;
    step(1'b1);
    step(1'b0);
    repeat (6) per(2, 1);

    step(1'b1);
    step(1'b1);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) per(2, 1);
    step(1'b1);
    repeat (3) @(negedge clk);

    check("sb_drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
